input_debounce_2ch: RTL
=======================

// Module: input_debounce_2ch
// PURPOSE
//  Two-channel synchronizer and debouncer for raw switch/button inputs.
//  Sits directly upstream of the two-input gate stage and feeds it clean operands a_clean/b_clean.
//  Each channel is double-flop synchronized, then accepted only after DB_CYCLES consecutive stable samples.
// PARAMETERS
//  DB_CYCLES  50000  consecutive stable cycles required to accept a level change (1 ms @ 50 MHz); legal range 2..2**CNT_W-1
//  CNT_W      16     debounce counter width; must satisfy 2**CNT_W > DB_CYCLES
// PORTS
//  clk      in   1  single system clock, all logic on rising edge
//  rst_n    in   1  asynchronous, active-low reset
//  a_raw    in   1  raw asynchronous input, channel A
//  b_raw    in   1  raw asynchronous input, channel B
//  a_clean  out  1  debounced level, channel A (to gate input a)
//  b_clean  out  1  debounced level, channel B (to gate input b)
//  a_rise   out  1  1-cycle pulse on accepted 0->1 of a_clean (see CONFIGURATION)
//  a_fall   out  1  1-cycle pulse on accepted 1->0 of a_clean
//  b_rise   out  1  1-cycle pulse on accepted 0->1 of b_clean
//  b_fall   out  1  1-cycle pulse on accepted 1->0 of b_clean
// BEHAVIOUR
//  - Reset: while rst_n=0, sync flops=0, counters=0, FSMs=S_LO, and all outputs=0; takes effect immediately, no clock needed.
//  - Sync: raw -> s1 -> s2 (2 flops). s2 is the only value the FSM sees.
//  - Per-channel FSM (identical, independent):
//      S_LO:   s2=1 -> S_CHK_HI, cnt<=1; else stay, cnt<=0
//      S_CHK_HI: s2=0 -> S_LO, cnt<=0 (glitch rejected)
//                s2=1 & cnt==DB_CYCLES-1 -> S_HI, clean<=1, cnt<=0
//                s2=1 otherwise -> cnt<=cnt+1
//      S_HI / S_CHK_LO: mirror image with polarity swapped
//  - clean is 1 exactly in S_HI and S_CHK_LO; registered, never combinational.
//  - Latency: a raw level held from before edge k is reflected on clean after edge k+DB_CYCLES+1.
//  - A pulse that leaves s2 in one state for fewer than DB_CYCLES cycles never changes clean.
//  - Any reversal during CHK clears cnt; the next change restarts the full DB_CYCLES count.
//  - cnt never exceeds DB_CYCLES-1, so there is no wrap-around.
//  - Channels are independent: simultaneous changes on A and B resolve on the same edge if their timing is identical.
//  - Reset asserted mid-CHK discards progress. After release, the channel starts from S_LO with clean=0.
// CONFIGURATION
//  - Macro EDGE_PULSE_EN.
//  - Defined: each *_rise/*_fall output is a registered 1-cycle pulse asserted in the same cycle clean changes.
//    Rise and fall pulses never coincide on one channel.
//  - Undefined: pulse logic is not built; a_rise, a_fall, b_rise and b_fall are tied to 0.
//  - clean behaviour is identical in both builds.
// STRUCTURE
//  - Shared package debounce_pkg holds:
//    - state encoding localparams S_LO=2'd0, S_CHK_HI=2'd1, S_HI=2'd2, S_CHK_LO=2'd3
//    - default DB_CYCLES
//  - One sub-module debounce_ch (sync + FSM + counter for one input), instantiated twice.
//  - The top level only wires the two instances together.
// TESTING  (bench overrides DB_CYCLES=4, CNT_W=3)
//  1. Hold rst_n=0 with a_raw=b_raw=1 -> every output stays 0.
//     Release rst_n with both inputs still 1 -> a_clean=b_clean=1 after edge 5 post-release.
//  2. a_raw 0->1 held high -> a_clean rises after edge k+5.
//     With EDGE_PULSE_EN, a_rise=1 for exactly that one cycle. b_clean stays unchanged.
//  3. a_raw high-pulses of 1, 2 and 3 cycles separated by 5 low cycles -> a_clean stays 0 and no pulses fire.
//  4. a_raw bounces 1,0,1,0,1 then holds 1 -> a_clean rises 5 edges after the final 0->1 only.
//  5. a_raw and b_raw rise on the same edge -> a_clean and b_clean rise on the same edge.
//     Later, b falls while a is held -> only b_clean and b_fall change.
//  6. Assert rst_n low 2 cycles into a CHK_HI count -> outputs go 0 immediately.
//     After release with input held high -> a full 5-edge latency again.
//     Build without EDGE_PULSE_EN -> all pulse outputs stay 0 through scenarios 1-5.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and defaults for the two-channel debouncer
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LO     = 2'd0,
    S_CHK_HI = 2'd1,
    S_HI     = 2'd2,
    S_CHK_LO = 2'd3
  } db_state_e;

  localparam int DB_CYCLES_DEFAULT = 50000;
  localparam int CNT_W_DEFAULT     = 16;

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one channel: 2-flop synchronizer, debounce FSM and counter
// Optional EDGE_PULSE_EN builds registered rise/fall pulses; otherwise they are tied low.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q;
  logic             s2_q;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clean_q;
`ifdef EDGE_PULSE_EN
  logic             rise_q;
  logic             fall_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= S_LO;
      cnt_q   <= '0;
      clean_q <= 1'b0;
`ifdef EDGE_PULSE_EN
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`endif
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
`ifdef EDGE_PULSE_EN
      rise_q <= 1'b0;
      fall_q <= 1'b0;
`endif
      case (state_q)
        S_LO: begin
          if (s2_q) begin
            state_q <= S_CHK_HI;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        S_CHK_HI: begin
          if (!s2_q) begin
            state_q <= S_LO;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_HI;
            clean_q <= 1'b1;
            cnt_q   <= '0;
`ifdef EDGE_PULSE_EN
            rise_q  <= 1'b1;
`endif
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        S_HI: begin
          if (!s2_q) begin
            state_q <= S_CHK_LO;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        default: begin
          // S_CHK_LO: clean stays 1 until the low level is proven stable
          if (s2_q) begin
            state_q <= S_HI;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_LO;
            clean_q <= 1'b0;
            cnt_q   <= '0;
`ifdef EDGE_PULSE_EN
            fall_q  <= 1'b1;
`endif
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign clean_o = clean_q;
`ifdef EDGE_PULSE_EN
  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/input_debounce_2ch.sv
// rtl/input_debounce_2ch.sv - two independent debounced channels feeding the gate stage
// Edge pulses are built only when EDGE_PULSE_EN is defined.
module input_debounce_2ch
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_clean,
  output logic b_clean,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (a_raw),
    .clean_o (a_clean),
    .rise_o  (a_rise),
    .fall_o  (a_fall)
  );

  debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (b_raw),
    .clean_o (b_clean),
    .rise_o  (b_rise),
    .fall_o  (b_fall)
  );

endmodule
